// File: rtl/median_filter_pkg.sv
// median_filter_pkg
//   Shared constants and helpers for the pipelined rank-order filter.
//   - MODE_*       : encodings of the per-window rank select
//   - median_index : position of the median in an ascending window of n samples
package median_filter_pkg;

  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_MIN    = 2'b01;
  localparam logic [1:0] MODE_MAX    = 2'b10;
  // 2'b11 is reserved and decodes as median.

  function automatic int median_index(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/median_sort_stage.sv
// median_sort_stage
//   One registered layer of an odd-even transposition sort network.
//   ODD=1 compares pairs (0,1),(2,3),...; ODD=0 compares (1,2),(3,4),...
//   Each compared pair leaves ascending; an unpaired end lane passes through.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   vec/valid/mode  : incoming window, its valid flag and rank select
//   vec_r/valid_r/mode_r : the same after this layer, registered
module median_sort_stage
  import median_filter_pkg::*;
#(
  parameter int W   = 8,
  parameter int N   = 7,
  parameter bit ODD = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] vec,
  input  logic           valid,
  input  logic [1:0]     mode,
  output logic [N*W-1:0] vec_r,
  output logic           valid_r,
  output logic [1:0]     mode_r
);

  localparam int FIRST = ODD ? 0 : 1;

  logic [N*W-1:0] swap_s;

  // Compare-and-swap every pair owned by this layer; equal values stay put.
  always_comb begin
    swap_s = vec;
    for (int i = FIRST; i + 1 < N; i += 2) begin
      if (vec[i*W +: W] > vec[(i+1)*W +: W]) begin
        swap_s[i*W +: W]     = vec[(i+1)*W +: W];
        swap_s[(i+1)*W +: W] = vec[i*W +: W];
      end else begin
        swap_s[i*W +: W]     = vec[i*W +: W];
        swap_s[(i+1)*W +: W] = vec[(i+1)*W +: W];
      end
    end
  end

  // Pipeline register for this layer; reset drops whatever window is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r   <= {(N*W){1'b0}};
      valid_r <= 1'b0;
      mode_r  <= MODE_MEDIAN;
    end else begin
      vec_r   <= swap_s;
      valid_r <= valid;
      mode_r  <= mode;
    end
  end

endmodule

// File: rtl/median_filter_pipe.sv
// median_filter_pipe
//   Fully pipelined rank-order filter: one window of N unsigned W-bit samples
//   per clock, result (median/min/max) N+2 registers later. No back-pressure.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : window on in_data is valid
//   in_data   : N*W bits, sample i at [i*W +: W]
//   in_mode   : 00 median, 01 min, 10 max, 11 reserved (median)
//   out_valid : out_data holds a result
//   out_data  : selected rank value, zero when out_valid is low
//   out_mode  : in_mode that travelled with this window
module median_filter_pipe
  import median_filter_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_mode
);

  localparam int MED = median_index(N);

  if ((N < 3) || ((N % 2) == 0)) begin : g_bad_window
    $error("median_filter_pipe: N must be odd and at least 3");
  end

  // Index 0 is the input register; index k is the output of sort layer k.
  logic [N*W-1:0] vec_s  [0:N];
  logic [N:0]     valid_s;
  logic [1:0]     mode_s [0:N];

  logic [N*W-1:0] in_vec_r;
  logic           in_valid_r;
  logic [1:0]     in_mode_r;
  logic [W-1:0]   sel_s;

  // Input register: capture the window every cycle, drop it under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vec_r   <= {(N*W){1'b0}};
      in_valid_r <= 1'b0;
      in_mode_r  <= MODE_MEDIAN;
    end else begin
      in_vec_r   <= in_data;
      in_valid_r <= in_valid;
      in_mode_r  <= in_mode;
    end
  end

  assign vec_s[0]   = in_vec_r;
  assign valid_s[0] = in_valid_r;
  assign mode_s[0]  = in_mode_r;

  // N alternating layers fully sort an N-element vector.
  for (genvar k = 1; k <= N; k++) begin : g_stage
    median_sort_stage #(
      .W   (W),
      .N   (N),
      .ODD ((k % 2) == 1)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .vec     (vec_s[k-1]),
      .valid   (valid_s[k-1]),
      .mode    (mode_s[k-1]),
      .vec_r   (vec_s[k]),
      .valid_r (valid_s[k]),
      .mode_r  (mode_s[k])
    );
  end

  // Pick the requested rank from the sorted vector; reserved mode means median.
  always_comb begin
    sel_s = {W{1'b0}};
    case (mode_s[N])
      MODE_MIN: sel_s = vec_s[N][0 +: W];
      MODE_MAX: sel_s = vec_s[N][(N-1)*W +: W];
      default:  sel_s = vec_s[N][MED*W +: W];
    endcase
  end

  // Output register: data is forced to zero on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {W{1'b0}};
      out_mode  <= MODE_MEDIAN;
    end else begin
      out_valid <= valid_s[N];
      out_mode  <= mode_s[N];
      out_data  <= valid_s[N] ? sel_s : {W{1'b0}};
    end
  end

endmodule
